// File: rtl/mem_scan_ctrl_pkg.sv
// Shared mode encodings and FSM state type for the RAM scan controller.
package mem_scan_ctrl_pkg;

    localparam logic [1:0] MODE_SCAN     = 2'b00;
    localparam logic [1:0] MODE_MANUAL   = 2'b01;
    localparam logic [1:0] MODE_FILL     = 2'b10;
    localparam logic [1:0] MODE_SCAN_ALT = 2'b11;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StWrite = 2'b01,
        StFill  = 2'b10
    } state_e;

endpackage

// File: rtl/mem_scan_ram.sv
// Inferred single-port synchronous RAM with registered read data (one-cycle latency).
module mem_scan_ram #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] r_rdata;

    // No reset: contents must survive a controller reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_scan_ctrl.sv
// RAM controller: switch write, bulk fill, auto-scan or manual read, last read latched for HEX.
module mem_scan_ctrl
    import mem_scan_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic              CLOCK_50,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              wr_req,
    output logic              busy,
    output logic              wr_led,
    output logic [ADDR_W-1:0] show_addr,
    output logic [DATA_W-1:0] show_data,
    output logic              show_valid
);

    localparam int unsigned TW = $clog2(TICK_DIV);

    logic [1:0]        r_mode_s1, r_mode_s2;
    logic [ADDR_W-1:0] r_addr_s1, r_addr_s2;
    logic [DATA_W-1:0] r_data_s1, r_data_s2;
    logic              r_wr_s1, r_wr_s2, r_wr_s3;
    logic [TW-1:0]     r_tick_cnt;
    state_e            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_fill_ptr, r_scan_ptr, r_op_addr, r_rd_addr, r_show_addr;
    logic [DATA_W-1:0] r_op_data, r_show_data;
    logic              r_fill_lock, r_rd_vld, r_show_valid;

    logic              w_tick, w_wr_rise, w_manual, w_auto, w_fill_last;
    logic              w_go_fill, w_go_write, w_rd_issue, w_we;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [DATA_W-1:0] w_ram_q;

    assign w_tick      = (r_tick_cnt == TW'(TICK_DIV - 1));
    assign w_wr_rise   = r_wr_s2 & ~r_wr_s3;
    assign w_manual    = (r_mode_s2 == MODE_MANUAL);
    assign w_auto      = (r_mode_s2 == MODE_SCAN) || (r_mode_s2 == MODE_SCAN_ALT);
    assign w_fill_last = (r_state == StFill) && (r_fill_ptr == '1);

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Priority in idle: fill, then write, then read.
    always_comb begin
        w_state_nxt = r_state;
        w_go_fill   = 1'b0;
        w_go_write  = 1'b0;
        w_rd_issue  = 1'b0;
        w_we        = 1'b0;
        w_ram_addr  = w_manual ? r_addr_s2 : r_scan_ptr;
        unique case (r_state)
            StIdle: begin
                if ((r_mode_s2 == MODE_FILL) && !r_fill_lock) begin
                    w_go_fill   = 1'b1;
                    w_state_nxt = StFill;
                end else if (w_wr_rise) begin
                    w_go_write  = 1'b1;
                    w_state_nxt = StWrite;
                end else begin
                    w_rd_issue = w_manual || (w_auto && w_tick);
                end
            end
            StWrite: begin
                w_we        = 1'b1;
                w_ram_addr  = r_op_addr;
                w_state_nxt = StIdle;
            end
            StFill: begin
                w_we       = 1'b1;
                w_ram_addr = r_fill_ptr;
                if (w_fill_last) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_mode_s1    <= '0;
            r_mode_s2    <= '0;
            r_addr_s1    <= '0;
            r_addr_s2    <= '0;
            r_data_s1    <= '0;
            r_data_s2    <= '0;
            r_wr_s1      <= 1'b0;
            r_wr_s2      <= 1'b0;
            r_wr_s3      <= 1'b0;
            r_tick_cnt   <= '0;
            r_fill_ptr   <= '0;
            r_scan_ptr   <= '0;
            r_op_addr    <= '0;
            r_op_data    <= '0;
            r_fill_lock  <= 1'b0;
            r_rd_vld     <= 1'b0;
            r_rd_addr    <= '0;
            r_show_addr  <= '0;
            r_show_data  <= '0;
            r_show_valid <= 1'b0;
        end else begin
            r_mode_s1  <= mode;
            r_mode_s2  <= r_mode_s1;
            r_addr_s1  <= addr_in;
            r_addr_s2  <= r_addr_s1;
            r_data_s1  <= data_in;
            r_data_s2  <= r_data_s1;
            r_wr_s1    <= wr_req;
            r_wr_s2    <= r_wr_s1;
            r_wr_s3    <= r_wr_s2;
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;

            if (w_go_fill) begin
                r_fill_ptr <= '0;
                r_op_data  <= r_data_s2;
            end else if (r_state == StFill) begin
                r_fill_ptr <= r_fill_ptr + 1'b1;
            end
            if (w_go_write) begin
                r_op_addr <= r_addr_s2;
                r_op_data <= r_data_s2;
            end

            // A held fill mode must leave 10 before another fill can start.
            if (w_fill_last) begin
                r_fill_lock <= 1'b1;
            end else if (r_mode_s2 != MODE_FILL) begin
                r_fill_lock <= 1'b0;
            end

            if (w_rd_issue && !w_manual) begin
                r_scan_ptr <= r_scan_ptr + 1'b1;
            end

            r_rd_vld  <= w_rd_issue;
            r_rd_addr <= w_ram_addr;
            if (r_rd_vld) begin
                r_show_addr  <= r_rd_addr;
                r_show_data  <= w_ram_q;
                r_show_valid <= 1'b1;
            end
        end
    end

    mem_scan_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .i_clk   (CLOCK_50),
        .i_we    (w_we),
        .i_addr  (w_ram_addr),
        .i_wdata (r_op_data),
        .o_rdata (w_ram_q)
    );

    assign busy       = (r_state == StFill);
    assign wr_led     = w_we;
    assign show_addr  = r_show_addr;
    assign show_data  = r_show_data;
    assign show_valid = r_show_valid;

endmodule

// File: tb/tb_mem_scan_ctrl.sv
// Directed bench for mem_scan_ctrl with ADDR_W=5, DATA_W=8, TICK_DIV=4.
module tb_mem_scan_ctrl;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 8;
    localparam int unsigned TD = 4;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic [1:0]    mode    = 2'b00;
    logic [AW-1:0] addr_in = '0;
    logic [DW-1:0] data_in = '0;
    logic          wr_req  = 1'b0;
    logic          busy, wr_led, show_valid;
    logic [AW-1:0] show_addr;
    logic [DW-1:0] show_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_scan_ctrl #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .TICK_DIV (TD)
    ) dut (
        .CLOCK_50   (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .addr_in    (addr_in),
        .data_in    (data_in),
        .wr_req     (wr_req),
        .busy       (busy),
        .wr_led     (wr_led),
        .show_addr  (show_addr),
        .show_data  (show_data),
        .show_valid (show_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic count_busy(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (busy) cnt++;
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        addr_in = a;
        data_in = d;
        wr_req  = 1'b1;
        wait_neg(4);
        wr_req  = 1'b0;
        wait_neg(4);
    endtask

    task automatic read_check(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
        addr_in = a;
        wait_neg(6);
        check({tag, "_addr"}, 32'(show_addr), 32'(a));
        check({tag, "_data"}, 32'(show_data), 32'(d));
    endtask

    initial begin
        int cnt;
        int found;

        // Outputs while held in reset
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_led", 32'(wr_led), 32'd0);
        check("rst_show_addr", 32'(show_addr), 32'd0);
        check("rst_show_data", 32'(show_data), 32'd0);
        check("rst_show_valid", 32'(show_valid), 32'd0);
        wait_neg(3);
        rst_n = 1'b1;

        // Fill with A5; a write pulse and data change mid-fill must not land
        mode    = 2'b10;
        data_in = 8'hA5;
        addr_in = 5'h07;
        cnt     = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (busy) cnt++;
            if (i == 2) check("fill_busy_pre", 32'(busy), 32'd0);
            if (i == 3) check("fill_busy_start", 32'(busy), 32'd1);
            if (i == 10) begin
                wr_req  = 1'b1;
                data_in = 8'h99;
            end
            if (i == 14) wr_req = 1'b0;
        end
        check("fill_busy_cycles", 32'(cnt), 32'd32);

        mode = 2'b01;
        read_check("fill_rd00", 5'h00, 8'hA5);
        check("show_valid_set", 32'(show_valid), 32'd1);
        read_check("fill_rd11", 5'h11, 8'hA5);
        read_check("fill_rd1f", 5'h1F, 8'hA5);
        read_check("fill_rd07", 5'h07, 8'hA5);

        // Write held high for 100 cycles gives exactly one commit
        addr_in = 5'h03;
        data_in = 8'h3C;
        wait_neg(4);
        wr_req = 1'b1;
        cnt    = 0;
        for (int i = 1; i <= 110; i++) begin
            @(negedge clk);
            if (wr_led) cnt++;
            if (i == 100) wr_req = 1'b0;
        end
        check("write_one_pulse", 32'(cnt), 32'd1);
        check("write_rd_addr", 32'(show_addr), 32'h03);
        check("write_rd_data", 32'(show_data), 32'h3C);

        // Manual read latency
        addr_in = 5'h00;
        wait_neg(6);
        addr_in = 5'h03;
        wait_neg(3);
        check("lat_early_addr", 32'(show_addr), 32'h00);
        wait_neg(1);
        check("lat_addr", 32'(show_addr), 32'h03);
        check("lat_data", 32'(show_data), 32'h3C);

        // Fill with 00, mode held at 10 afterwards: no second fill
        mode    = 2'b10;
        data_in = 8'h00;
        count_busy(45, cnt);
        check("fill2_held_cycles", 32'(cnt), 32'd32);
        mode = 2'b00;
        wait_neg(4);
        mode = 2'b10;
        count_busy(45, cnt);
        check("fill_retrigger_cycles", 32'(cnt), 32'd32);

        mode = 2'b01;
        do_write(5'h1F, 8'h11);
        do_write(5'h00, 8'h22);

        // Auto scan across the wrap point
        addr_in = 5'h0A;
        data_in = 8'h5A;
        mode    = 2'b00;
        found   = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (show_addr == 5'h1E) begin
                found = 1;
                break;
            end
        end
        check("scan_find_1e", 32'(found), 32'd1);
        if (found == 1) begin
            check("scan_1e_data", 32'(show_data), 32'h00);
            wait_neg(2);
            check("scan_1e_hold", 32'(show_addr), 32'h1E);
            wait_neg(2);
            check("scan_1f_addr", 32'(show_addr), 32'h1F);
            check("scan_1f_data", 32'(show_data), 32'h11);
            wait_neg(4);
            check("scan_00_addr", 32'(show_addr), 32'h00);
            check("scan_00_data", 32'(show_data), 32'h22);
            wait_neg(4);
            check("scan_01_addr", 32'(show_addr), 32'h01);
            check("scan_01_data", 32'(show_data), 32'h00);

            // Write edge lands on the next tick: that scan step is skipped
            wr_req = 1'b1;
            wait_neg(4);
            check("collide_skip", 32'(show_addr), 32'h01);
            wait_neg(4);
            check("collide_next_addr", 32'(show_addr), 32'h02);
            check("collide_next_data", 32'(show_data), 32'h00);
            wr_req = 1'b0;
        end

        mode = 2'b01;
        read_check("collide_write", 5'h0A, 8'h5A);

        // Asynchronous reset in the middle of a fill
        mode = 2'b10;
        wait_neg(10);
        check("midfill_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_wr_led", 32'(wr_led), 32'd0);
        check("arst_show_valid", 32'(show_valid), 32'd0);
        check("arst_show_addr", 32'(show_addr), 32'd0);
        check("arst_show_data", 32'(show_data), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
